// File: rtl/song_sequencer_if.sv
// Song ROM bus and note_player handshake bundled between song_sequencer and its neighbours.
interface song_sequencer_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
);
  logic [SONG_W+IDX_W-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note_to_load;
  logic                    load_new_note;
  logic                    note_done;
  logic                    song_done;

  modport master (
    output rom_addr, note_to_load, load_new_note, note_done, song_done,
    input  rom_data
  );

  modport slave (
    input  rom_addr, note_to_load, load_new_note, note_done, song_done,
    output rom_data
  );
endinterface

// File: rtl/song_sequencer.sv
// Walks a song in an external synchronous ROM, loading each note into note_player
// and holding it for its duration in counted beats.
module song_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              restart,
  input  logic [SONG_W-1:0] song,
  input  logic              beat,
  song_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [DUR_W-1:0]    remaining_q, remaining_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                note_done_q, note_done_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                counted_beat;

  assign rom_note     = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur      = bus.rom_data[DUR_W-1:0];
  assign counted_beat = beat && play;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      song_q      <= '0;
      remaining_q <= '0;
      note_q      <= '0;
      note_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      song_q      <= song_d;
      remaining_q <= remaining_d;
      note_q      <= note_d;
      note_done_q <= note_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    song_d      = song_q;
    remaining_d = remaining_q;
    note_d      = note_q;
    note_done_d = 1'b0;

    // restart overrides everything, including a beat arriving in the same cycle
    if (restart) begin
      state_d     = S_IDLE;
      index_d     = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            song_d  = song;
            index_d = '0;
            state_d = S_FETCH_A;
          end
        end
        S_FETCH_A: state_d = S_FETCH_B;
        S_FETCH_B: begin
          // a zero duration marks the end of the song
          if (rom_dur == '0) begin
            state_d = S_DONE;
          end else begin
            note_d      = rom_note;
            remaining_d = rom_dur;
            state_d     = S_LOAD;
          end
        end
        S_LOAD: state_d = S_PLAY;
        S_PLAY: begin
          if (counted_beat) begin
            if (remaining_q == DUR_W'(1)) begin
              note_done_d = 1'b1;
              if (index_q == '1) begin
                state_d = S_DONE;
              end else begin
                index_d = index_q + IDX_W'(1);
                state_d = S_FETCH_A;
              end
            end else begin
              remaining_d = remaining_q - DUR_W'(1);
            end
          end
        end
        S_DONE: begin
          if (!play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr      = {song_q, index_q};
  assign bus.note_to_load  = note_q;
  assign bus.load_new_note = (state_q == S_LOAD);
  assign bus.note_done     = note_done_q;
  assign bus.song_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized scoreboard bench for song_sequencer with a behavioural song ROM.
module tb_song_sequencer;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              play = 1'b0;
  logic              restart = 1'b0;
  logic              beat = 1'b0;
  logic [SONG_W-1:0] song = '0;

  song_sequencer_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)) bus ();

  song_sequencer #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .play    (play),
    .restart (restart),
    .song    (song),
    .beat    (beat),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [NOTE_W+DUR_W-1:0] rom [128];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef enum int {EV_NONE = -1, EV_LOAD = 0, EV_NDONE = 1, EV_SDONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       note;
    int       addr;
    int       dur;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expected event stream of a whole song, from the ROM contents alone.
  task automatic push_song(input int s);
    for (int i = 0; i < 32; i++) begin
      logic [NOTE_W+DUR_W-1:0] w;
      w = rom[s*32 + i];
      if (w[DUR_W-1:0] == '0) begin
        sb.push_back('{EV_SDONE, 0, 0, 0});
        return;
      end
      sb.push_back('{EV_LOAD, int'(w[NOTE_W+DUR_W-1:DUR_W]), s*32 + i, 0});
      sb.push_back('{EV_NDONE, 0, 0, int'(w[DUR_W-1:0])});
    end
    sb.push_back('{EV_SDONE, 0, 0, 0});
  endtask

  // Monitor: counts beats actually delivered while a note is sounding.
  ev_t e;
  int  beat_cnt = 0;
  bit  counting = 1'b0;
  bit  prev_sd  = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      counting = 1'b0;
      prev_sd  = 1'b0;
    end else begin
      if (bus.note_done) begin
        if (sb.size() > 0) e = sb.pop_front(); else e = '{EV_NONE, 0, 0, 0};
        check("event at note_done", EV_NDONE, e.kind);
        if (e.kind == EV_NDONE) check("counted beats per note", beat_cnt, e.dur);
        counting = 1'b0;
      end else if (counting && beat && play && !restart) begin
        beat_cnt++;
      end
      if (bus.load_new_note) begin
        if (sb.size() > 0) e = sb.pop_front(); else e = '{EV_NONE, 0, 0, 0};
        check("event at load_new_note", EV_LOAD, e.kind);
        if (e.kind == EV_LOAD) begin
          check("note_to_load", bus.note_to_load, e.note);
          check("rom_addr at load", bus.rom_addr, e.addr);
        end
        counting = 1'b1;
        beat_cnt = 0;
      end
      if (bus.song_done && !prev_sd) begin
        if (sb.size() > 0) e = sb.pop_front(); else e = '{EV_NONE, 0, 0, 0};
        check("event at song_done", EV_SDONE, e.kind);
      end
      prev_sd = bus.song_done;
      if (restart) begin
        sb.delete();
        counting = 1'b0;
      end
    end
  end

  task automatic run_song(input int s, input int period, input bit pauses, input int restart_at);
    bit done_seen = 1'b0;
    bit aborted   = 1'b0;
    @(posedge clk); #2;
    song = SONG_W'(s); play = 1'b1; beat = 1'b0; restart = 1'b0;
    push_song(s);
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(posedge clk); #2;
      restart = 1'b0;
      if (aborted) break;
      if (bus.song_done) begin
        done_seen = 1'b1;
        break;
      end
      if (cyc == restart_at) begin
        restart = 1'b1; beat = 1'b1; play = 1'b1;
        aborted = 1'b1;
      end else begin
        beat = (period > 0) ? (cyc % period == 0) : ($urandom_range(3) == 0);
        play = pauses ? ($urandom_range(4) != 0) : 1'b1;
        if ($urandom_range(7) == 0) song = SONG_W'($urandom);
      end
    end
    restart = 1'b0; beat = 1'b0; play = 1'b0;
    if (!done_seen && !aborted) check("song_done within budget", bus.song_done, 1);
    if (done_seen) begin
      @(posedge clk); #2;
      check("song_done cleared after play low", bus.song_done, 0);
    end
  endtask

  initial begin
    rom[0] = {6'd1, 6'd2};
    rom[1] = {6'd13, 6'd1};
    rom[2] = '0;
    for (int i = 3; i < 32; i++) rom[i] = 12'($urandom);
    for (int i = 32; i < 64; i++) rom[i] = {6'($urandom), 6'd1};
    rom[64] = {6'd7, 6'd1};
    for (int i = 65; i < 96; i++) rom[i] = {6'($urandom), 6'($urandom_range(3, 1))};
    rom[64 + $urandom_range(15, 5)] = '0;
    for (int i = 96; i < 128; i++)
      rom[i] = {($urandom_range(4) == 0) ? 6'd0 : 6'($urandom), 6'($urandom_range(4, 1))};

    repeat (3) @(posedge clk);
    #2;
    check("reset rom_addr", bus.rom_addr, 0);
    check("reset note_to_load", bus.note_to_load, 0);
    check("reset load_new_note", bus.load_new_note, 0);
    check("reset note_done", bus.note_done, 0);
    check("reset song_done", bus.song_done, 0);
    reset = 1'b1;

    run_song(0, 10, 1'b0, -1);
    run_song(1, 0, 1'b0, -1);
    run_song(2, 0, 1'b1, -1);
    run_song(0, 0, 1'b1, -1);
    run_song(3, 0, 1'b1, int'($urandom_range(200, 20)));
    for (int r = 0; r < 6; r++)
      run_song(int'($urandom_range(3)), 0, 1'b1,
               ($urandom_range(2) == 0) ? int'($urandom_range(150, 10)) : -1);

    // asynchronous reset between clock edges while a note is playing
    @(posedge clk); #2;
    song = 2'd3; play = 1'b1;
    push_song(3);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      beat = ($urandom_range(2) == 0);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async reset rom_addr", bus.rom_addr, 0);
    check("async reset note_to_load", bus.note_to_load, 0);
    check("async reset load_new_note", bus.load_new_note, 0);
    check("async reset note_done", bus.note_done, 0);
    check("async reset song_done", bus.song_done, 0);
    @(posedge clk); #2;
    beat = 1'b0; play = 1'b0;
    reset = 1'b1;
    run_song(0, 0, 1'b0, -1);

    repeat (5) @(posedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream neighbour of note_player.
- Walks a song stored in an external synchronous song ROM and presents each note to note_player through a note_to_load / load_new_note pulse.
- Holds each note for its duration in beats, counted from beat_generator pulses, then pulses note_done and fetches the next entry.
- Flags end-of-song, and supports pause (play low) and restart.

Parameters:
NOTE_W, 6, note code width; matches note_player note_to_load.
DUR_W, 6, duration field width, in beats.
IDX_W, 5, note index within one song (32 entries per song).
SONG_W, 2, song select width (4 songs).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
play  input  1  level; 1 = run/advance, 0 = pause.
restart  input  1  one-cycle pulse; abort and return to IDLE, index cleared.
song  input  SONG_W  song select; sampled only on IDLE->FETCH_A.
beat  input  1  one-cycle beat pulse from beat_generator.
rom_addr  output  SONG_W+IDX_W  {song_latched, index}; registered.
rom_data  input  NOTE_W+DUR_W  [11:6] note, [5:0] duration; valid 1 cycle after rom_addr changes.
note_to_load  output  NOTE_W  note code to note_player; registered, held until next load.
load_new_note  output  1  one-cycle pulse; note_to_load valid.
note_done  output  1  one-cycle pulse when current note's duration expires.
song_done  output  1  level; high in DONE state.

Behaviour:
- Reset (async, reset==0): state=IDLE, index=0, song_latched=0, remaining=0. All outputs 0: rom_addr, note_to_load, load_new_note, note_done, song_done.
- States: IDLE, FETCH_A, FETCH_B, LOAD, PLAY, DONE. Encoding is free.
- IDLE:
  - play==1 -> latch song, index=0, go FETCH_A.
- FETCH_A: rom_addr={song_latched,index} is registered and stable; ROM latency cycle; go FETCH_B.
- FETCH_B: capture rom_data.
  - duration==0 -> end-of-song marker -> DONE.
  - Otherwise note_to_load<=note, remaining<=duration -> LOAD.
- LOAD:
  - load_new_note=1 for exactly this cycle; go PLAY.
  - Fetch and load complete even if play==0.
- PLAY:
  - Counts only beats with play==1; beat while play==0 is ignored (pause).
  - On a counted beat with remaining==1: next cycle note_done=1 (one cycle).
  - If index==2^IDX_W-1: index does not wrap; go DONE.
  - Otherwise index+1 and go FETCH_A.
  - On a counted beat with remaining>1: remaining-1.
- Latency: note_done cycle T (state FETCH_A) -> FETCH_B at T+1 -> load_new_note at T+2.
- Note code 0 is a rest. It is loaded and timed like any note; silence is note_player's job.
- DONE:
  - song_done=1.
  - play==0 -> IDLE (song_done clears the same edge).
  - No fetches while in DONE.
- restart pulse, any state, has priority over every other transition: next state IDLE, index=0, remaining=0; no note_done or load_new_note that cycle. note_to_load retains its last value.
- Simultaneous beat and restart: restart wins; the beat is discarded.
- beat in any state other than PLAY is ignored; never queued.
- Reset asserted mid-note: immediate return to reset values, independent of clk.
- Width rules:
  - remaining is DUR_W bits, never underflows (duration 0 never enters PLAY).
  - rom_addr = SONG_W+IDX_W bits.

Test Plan:
- Reset, ROM song0 = {note1,dur2},{note13,dur1},{0,dur0}, play=1, beats every 10 cycles -> load_new_note with note_to_load=1; note_done after 2nd beat; note_to_load=13 load_new_note 2 cycles later; note_done after 1 beat; song_done=1; rom_addr sequence 0,1,2.
- Pause: in PLAY of {note5,dur3} drop play for 4 beats, then resume -> note_done only after 3 counted beats; remaining frozen during pause.
- Song select: song=2, entry 64={7,1} -> rom_addr=64 first; note_to_load=7. Change song mid-play -> no effect until IDLE.
- Restart mid-note (after 1 of 3 beats), same cycle as beat -> IDLE next cycle, no note_done; rom_addr returns to {song,0} on next play.
- Full-length song: 32 entries, all dur=1 -> 32 note_done pulses; after index 31, DONE with song_done=1; no wrap to index 0. play=0 -> IDLE, song_done=0.
- Async reset asserted between clock edges during PLAY -> all outputs 0 immediately; after release with play=1, restarts at rom_addr 0.
